// File: rtl/ab_pkg.sv
// Shared types for the a/b pair decoder.
//   ab_state_e : occupancy of the two-entry result buffer (EMPTY, ONE, TWO)
//   ab_res_t   : one decode result {res_bit, hold}
//   DEC_ONE / DEC_ZERO : results of the two decisive decode branches
package ab_pkg;

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_TWO   = 2'd2
    } ab_state_e;

    typedef struct packed {
        logic res_bit;
        logic hold;
    } ab_res_t;

    localparam int RES_W = $bits(ab_res_t);

    localparam ab_res_t DEC_ONE  = '{res_bit: 1'b1, hold: 1'b0};
    localparam ab_res_t DEC_ZERO = '{res_bit: 1'b0, hold: 1'b0};

endpackage

// File: rtl/ab_skid_buf.sv
// Two-entry skid buffer with a generic payload.
// The output comes only from flops. in_ready is registered and low during reset.
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   in_valid / in_ready  upstream handshake; in_ready is low while both entries are full
//   in_data  [DATA_W]    payload captured on accept
//   out_valid/out_ready  downstream handshake; the head holds steady until it is popped
//   out_data [DATA_W]    head entry
module ab_skid_buf
    import ab_pkg::*;
#(
    parameter int DATA_W = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data
);

    ab_state_e         state_q, state_d;
    logic              in_ready_q;
    logic              push, pop;
    logic              head_we, head_from_skid, skid_we;
    logic [DATA_W-1:0] head_q, skid_q;

    assign push     = in_valid & in_ready_q;
    assign pop      = (state_q != S_EMPTY) & out_ready;
    assign in_ready = in_ready_q;
    assign out_data = head_q;

    // State register. in_ready follows the next state, so it stays a flop output.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_EMPTY;
            in_ready_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            in_ready_q <= (state_d != S_TWO);
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_EMPTY: if (push)          state_d = S_ONE;
            S_ONE: begin
                if (push && !pop)       state_d = S_TWO;
                else if (pop && !push)  state_d = S_EMPTY;
            end
            S_TWO:   if (pop)           state_d = S_ONE;
            default:                    state_d = S_EMPTY;
        endcase
    end

    // Output and data-steering logic.
    // When an accept and a pop happen together in S_ONE, the new item goes straight to the head.
    always_comb begin
        out_valid      = (state_q != S_EMPTY);
        head_we        = 1'b0;
        head_from_skid = 1'b0;
        skid_we        = 1'b0;
        case (state_q)
            S_EMPTY: head_we = push;
            S_ONE: begin
                head_we = push & pop;
                skid_we = push & ~pop;
            end
            S_TWO: begin
                head_we        = pop;
                head_from_skid = 1'b1;
            end
            default: ;
        endcase
    end

    // Entry storage
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q <= '0;
            skid_q <= '0;
        end else begin
            if (head_we) head_q <= head_from_skid ? skid_q : in_data;
            if (skid_we) skid_q <= in_data;
        end
    end

endmodule

// File: rtl/ab_pair_decoder.sv
// Registered decode stage for 2-bit operand pairs {a,b}.
// Decode priority:
//   1. a[0]&b[0] gives 1.
//   2. Otherwise, a[1]|b[1] gives 0.
//   3. Otherwise, the decode is a hold: it reuses the last decisive result kept in hold_reg.
// Results pass through a two-entry skid buffer, so no combinational path runs from in_* to out_*.
// Optional build macro AB_HOLD_CNT_EN adds a saturating counter of accepted hold decodes.
// Without the macro, hold_cnt is tied to 0.
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   in_valid, in_ready, in_a, in_b  upstream operand pair handshake
//   out_valid, out_ready            downstream result handshake
//   out_bit, out_hold               decoded result; out_hold marks a hold-path result
//   hold_cnt [CNT_W]                accepted hold decodes, saturating
module ab_pair_decoder
    import ab_pkg::*;
#(
    parameter int   CNT_W     = 8,
    parameter logic HOLD_INIT = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_a,
    input  logic [1:0]       in_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_bit,
    output logic             out_hold,
    output logic [CNT_W-1:0] hold_cnt
);

    logic    accept_p0;
    ab_res_t dec_p0;
    ab_res_t res_p1;
    logic    hold_reg;

    assign accept_p0 = in_valid & in_ready;

    // Stage p0: decode the incoming pair
    always_comb begin
        dec_p0 = '{res_bit: hold_reg, hold: 1'b1};
        if (in_a[0] & in_b[0])      dec_p0 = DEC_ONE;
        else if (in_a[1] | in_b[1]) dec_p0 = DEC_ZERO;
    end

    // The hold register remembers only decisive results.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                         hold_reg <= HOLD_INIT;
        else if (accept_p0 && !dec_p0.hold) hold_reg <= dec_p0.res_bit;
    end

`ifdef AB_HOLD_CNT_EN
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
    endfunction

    logic [CNT_W-1:0] hold_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                        hold_cnt_q <= '0;
        else if (accept_p0 && dec_p0.hold) hold_cnt_q <= sat_inc(hold_cnt_q);
    end

    assign hold_cnt = hold_cnt_q;
`else
    assign hold_cnt = '0;
`endif

    // Stage p1: result buffer
    ab_skid_buf #(
        .DATA_W(RES_W)
    ) u_skid (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (dec_p0),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (res_p1)
    );

    assign out_bit  = res_p1.res_bit;
    assign out_hold = res_p1.hold;

endmodule

// File: tb/tb_ab_pair_decoder.sv
module tb_ab_pair_decoder;

    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [1:0]       in_a = 2'b00;
    logic [1:0]       in_b = 2'b00;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic             out_bit;
    logic             out_hold;
    logic [CNT_W-1:0] hold_cnt;

    int checks = 0;
    int errors = 0;

    // Expected results, encoded as {bit, hold}
    logic [1:0]       exp_q[$];
    logic             hold_m = 1'b0;
    logic [CNT_W-1:0] cnt_m  = '0;

    ab_pair_decoder #(.CNT_W(CNT_W), .HOLD_INIT(1'b0)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_a     (in_a),
        .in_b     (in_b),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_bit  (out_bit),
        .out_hold (out_hold),
        .hold_cnt (hold_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Model of the decode rule; used for the streaming pattern only
    function automatic logic [1:0] model(input logic [1:0] a, input logic [1:0] b);
        if (a[0] & b[0]) return 2'b10;
        if (a[1] | b[1]) return 2'b00;
        return {hold_m, 1'b1};
    endfunction

    task automatic note_accept(input logic [1:0] exp);
        exp_q.push_back(exp);
        if (!exp[0]) hold_m = exp[1];
`ifdef AB_HOLD_CNT_EN
        else if (cnt_m != '1) cnt_m = cnt_m + 1'b1;
`endif
    endtask

    // Hold the pair on the inputs until it is accepted, or until the wait limit runs out
    task automatic send(input logic [1:0] a, input logic [1:0] b, input logic [1:0] exp);
        int waited;
        waited = 0;
        in_a = a; in_b = b; in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (!in_ready) begin
            checks++; errors++;
            $display("FAIL accept_timeout: in_ready got 0 expected 1");
            in_valid = 1'b0;
            return;
        end
        note_accept(exp);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst_n = 1'b0;
        exp_q.delete();
        hold_m = 1'b0;
        cnt_m  = '0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    // Scoreboard monitor: compare every result the downstream side takes
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_out: got %0b expected no result", {out_bit, out_hold});
            end else begin
                logic [1:0] e;
                e = exp_q.pop_front();
                if ({out_bit, out_hold} !== e) begin
                    errors++;
                    $display("FAIL result {bit,hold}: got %0b expected %0b", {out_bit, out_hold}, e);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation ran past time limit");
        $fatal(1, "timeout");
    end

    initial begin
        logic [3:0] v;
        int         drain;

        // Reset state
        @(negedge clk);
        chk("rst_in_ready",  in_ready,  0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_bit",   out_bit,   0);
        chk("rst_out_hold",  out_hold,  0);
        chk("rst_hold_cnt",  hold_cnt,  0);
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk);
        chk("rel_in_ready_0", in_ready, 0);
        @(negedge clk);
        chk("rel_in_ready_1", in_ready, 1);
        @(posedge clk); #1;

        // Test 1: a single decisive pair gives its result one cycle later
        out_ready = 1'b1;
        send(2'b01, 2'b01, 2'b10);
        @(negedge clk);
        chk("t1_latency_valid", out_valid, 1);
        @(posedge clk); #1;

        // Test 2: hold path starts from the hold-register reset value, then carries the last decisive result
        do_reset();
        send(2'b00, 2'b00, 2'b01);
        send(2'b10, 2'b00, 2'b00);
        send(2'b01, 2'b01, 2'b10);
        send(2'b00, 2'b00, 2'b11);
        @(negedge clk);
        chk("t2_hold_cnt", hold_cnt, cnt_m);
        @(posedge clk); #1;

        // Test 3: with out_ready low, two results fill the buffer and a third waits for the first pop
        out_ready = 1'b0;
        send(2'b11, 2'b01, 2'b10);
        send(2'b00, 2'b10, 2'b00);
        @(negedge clk);
        chk("t3_full_in_ready", in_ready, 0);
        chk("t3_full_valid", out_valid, 1);
        chk("t3_head_bit", out_bit, 1);
        @(posedge clk); #1;
        fork
            send(2'b01, 2'b00, 2'b01);
            begin
                repeat (3) @(posedge clk);
                #1;
                chk("t3_third_blocked", exp_q.size(), 2);
                out_ready = 1'b1;
            end
        join
        repeat (3) @(posedge clk); #1;

        // Test 4: stream all 16 pairs with no bubbles
        out_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            v = i[3:0];
            in_a = v[3:2]; in_b = v[1:0]; in_valid = 1'b1;
            @(negedge clk);
            chk("t4_stream_ready", in_ready, 1);
            if (i > 0) chk("t4_stream_valid", out_valid, 1);
            note_accept(model(v[3:2], v[1:0]));
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        @(negedge clk);
        chk("t4_last_valid", out_valid, 1);
        @(negedge clk);
        chk("t4_drained", out_valid, 0);
        @(posedge clk); #1;

        // Test 5: twenty hold decodes saturate the counter when it is built in
        for (int i = 0; i < 20; i++) send(2'b00, 2'b00, 2'b11);
        @(negedge clk);
`ifdef AB_HOLD_CNT_EN
        chk("t5_hold_cnt_sat", hold_cnt, 15);
`else
        chk("t5_hold_cnt_off", hold_cnt, 0);
`endif
        @(posedge clk); #1;

        // Test 6: an asynchronous reset while the buffer is full drops everything
        out_ready = 1'b0;
        send(2'b11, 2'b11, 2'b10);
        send(2'b10, 2'b10, 2'b00);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_async_valid", out_valid, 0);
        chk("t6_async_ready", in_ready,  0);
        chk("t6_async_bit",   out_bit,   0);
        chk("t6_async_hold",  out_hold,  0);
        chk("t6_async_cnt",   hold_cnt,  0);
        exp_q.delete();
        hold_m = 1'b0;
        cnt_m  = '0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("t6_no_stale", out_valid, 0);
        end
        @(posedge clk); #1;
        send(2'b00, 2'b00, 2'b01);

        // Drain the scoreboard
        drain = 0;
        while (exp_q.size() != 0 && drain < 20) begin
            @(posedge clk);
            drain++;
        end
        #1;
        chk("final_queue_empty", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
